memory_io_bridge: RTL and testbench

- Byte-lane steering bridge between the 16-bit CPU data port and the 16-bit word-organised RAM.
- Converts CPU byte addresses to word addresses and replicates write bytes onto both lanes.
- Generates RAM byte enables and the gated write strobe; extracts and extends read bytes.
- Only the misaligned-access status is clocked; all datapath logic is combinational. Sits between the CPU core and the RAM macro.

---
 rtl/memory_io_pkg.sv | 21 ++
 rtl/memio_byte_extract.sv | 18 +
 rtl/memory_io_bridge.sv | 96 +++++++++
 tb/tb_memory_io_bridge.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/memory_io_pkg.sv
// Shared types and constants for the CPU-to-RAM byte-lane bridge.
package memory_io_pkg;

    localparam int DW = 16;

    typedef enum logic [1:0] {
        SZ_IDLE  = 2'b00,
        SZ_UBYTE = 2'b01,
        SZ_SBYTE = 2'b10,
        SZ_WORD  = 2'b11
    } size_e;

    localparam logic LANE_LO = 1'b0;
    localparam logic LANE_HI = 1'b1;

    // Byte enable that addresses a single RAM lane.
    function automatic logic [1:0] lane_be(input logic lane);
        return (lane == LANE_HI) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/memio_byte_extract.sv
// Read-path byte lane: picks one byte of a RAM word and zero- or sign-extends it.
module memio_byte_extract
    import memory_io_pkg::*;
(
    input  logic [DW-1:0] word_i,
    input  logic          lane_i,
    input  logic          sign_ext_i,
    output logic [DW-1:0] data_o
);

    logic [7:0] byte_sel;

    always_comb begin
        byte_sel = (lane_i == LANE_HI) ? word_i[15:8] : word_i[7:0];
        data_o   = {{(DW-8){sign_ext_i & byte_sel[7]}}, byte_sel};
    end

endmodule

// File: rtl/memory_io_bridge.sv
// Byte-lane steering bridge between the 16-bit CPU port and word-organised RAM.
// Define MEMIO_BIG_ENDIAN_EN to swap the byte lanes (big-endian byte order).
module memory_io_bridge
    import memory_io_pkg::*;
#(
    parameter int AW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] CPUaddr,
    input  logic [1:0]    CPUbe,
    input  logic          CPUwe,
    input  logic [DW-1:0] CPUwrite,
    input  logic [DW-1:0] RAMread,
    output logic [AW-2:0] RAMaddr,
    output logic [DW-1:0] RAMwrite,
    output logic [1:0]    RAMbe,
    output logic          RAMwe,
    output logic [DW-1:0] CPUread,
    output logic          misalign_err,
    output logic [AW-1:0] err_addr
);

`ifdef MEMIO_BIG_ENDIAN_EN
    localparam logic LANE_SWAP = 1'b1;
`else
    localparam logic LANE_SWAP = 1'b0;
`endif

    size_e         size;
    logic          misaligned;
    logic          byte_lane;
    logic [DW-1:0] byte_data;

    logic          misalign_err_d, misalign_err_q;
    logic [AW-1:0] err_addr_d, err_addr_q;

    memio_byte_extract u_extract (
        .word_i     (RAMread),
        .lane_i     (byte_lane),
        .sign_ext_i (size == SZ_SBYTE),
        .data_o     (byte_data)
    );

    // NOTE: every output gets a default before the case so no latch is inferred
    // for the access sizes that leave it untouched.
    always_comb begin
        size       = size_e'(CPUbe);
        misaligned = (size == SZ_WORD) && CPUaddr[0];
        byte_lane  = CPUaddr[0] ^ LANE_SWAP;
        RAMaddr    = CPUaddr[AW-1:1];
        RAMwrite   = CPUwrite;
        RAMbe      = 2'b00;
        CPUread    = '0;
        case (size)
            SZ_UBYTE, SZ_SBYTE: begin
                RAMwrite = {2{CPUwrite[7:0]}};
                RAMbe    = lane_be(byte_lane);
                CPUread  = byte_data;
            end
            SZ_WORD: begin
                if (!misaligned) begin
                    RAMbe   = 2'b11;
                    CPUread = RAMread;
                end
            end
            default: ;
        endcase
        RAMwe = CPUwe && (size != SZ_IDLE) && !misaligned;
    end

    // Only the first misaligned access is recorded; later ones leave it intact.
    always_comb begin
        misalign_err_d = misalign_err_q;
        err_addr_d     = err_addr_q;
        if (misaligned && !misalign_err_q) begin
            misalign_err_d = 1'b1;
            err_addr_d     = CPUaddr;
        end
    end

    // NOTE: non-blocking assignments keep every flop updating from pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            misalign_err_q <= 1'b0;
            err_addr_q     <= '0;
        end else begin
            misalign_err_q <= misalign_err_d;
            err_addr_q     <= err_addr_d;
        end
    end

    assign misalign_err = misalign_err_q;
    assign err_addr     = err_addr_q;

endmodule

// File: tb/tb_memory_io_bridge.sv
// Self-checking bench for memory_io_bridge: directed steps plus random accesses
// compared against an arithmetic reference model.
module tb_memory_io_bridge;

`ifdef MEMIO_BIG_ENDIAN_EN
    localparam bit BIG = 1'b1;
`else
    localparam bit BIG = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic [15:0] CPUaddr;
    logic [1:0]  CPUbe;
    logic        CPUwe;
    logic [15:0] CPUwrite;
    logic [15:0] RAMread;
    logic [14:0] RAMaddr;
    logic [15:0] RAMwrite;
    logic [1:0]  RAMbe;
    logic        RAMwe;
    logic [15:0] CPUread;
    logic        misalign_err;
    logic [15:0] err_addr;

    int errors = 0;
    int checks = 0;
    int exp_err = 0;
    int exp_eaddr = 0;

    memory_io_bridge #(.AW(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .CPUaddr      (CPUaddr),
        .CPUbe        (CPUbe),
        .CPUwe        (CPUwe),
        .CPUwrite     (CPUwrite),
        .RAMread      (RAMread),
        .RAMaddr      (RAMaddr),
        .RAMwrite     (RAMwrite),
        .RAMbe        (RAMbe),
        .RAMwe        (RAMwe),
        .CPUread      (CPUread),
        .misalign_err (misalign_err),
        .err_addr     (err_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference behaviour from the access rules, using plain integer arithmetic.
    function automatic void model(input int addr, input int be, input int we, input int wr,
                                  input int rd, output int e_raddr, output int e_rwrite,
                                  output int e_rbe, output int e_rwe, output int e_cread,
                                  output int e_mis);
        int idx;
        int b;
        e_mis    = (be == 3 && addr % 2 == 1) ? 1 : 0;
        idx      = BIG ? 1 - addr % 2 : addr % 2;
        e_raddr  = addr / 2;
        e_rwrite = (be == 1 || be == 2) ? (wr % 256) * 257 : wr;
        b        = (rd >> (8 * idx)) % 256;
        e_rbe    = 0;
        e_cread  = 0;
        if (be == 1) begin
            e_rbe   = 1 << idx;
            e_cread = b;
        end else if (be == 2) begin
            e_rbe   = 1 << idx;
            e_cread = (b >= 128) ? b + 65280 : b;
        end else if (be == 3 && e_mis == 0) begin
            e_rbe   = 3;
            e_cread = rd;
        end
        e_rwe = (we != 0 && be != 0 && e_mis == 0) ? 1 : 0;
    endfunction

    // Drive one access and check all combinational outputs; returns the misaligned flag.
    task automatic apply(input string tag, input int addr, input int be, input int we,
                         input int wr, input int rd, output int mis);
        int e_raddr, e_rwrite, e_rbe, e_rwe, e_cread;
        CPUaddr  = 16'(addr);
        CPUbe    = 2'(be);
        CPUwe    = 1'(we);
        CPUwrite = 16'(wr);
        RAMread  = 16'(rd);
        #1;
        model(addr, be, we, wr, rd, e_raddr, e_rwrite, e_rbe, e_rwe, e_cread, mis);
        check({tag, ".RAMaddr"}, 32'(RAMaddr), 32'(e_raddr));
        check({tag, ".RAMbe"}, 32'(RAMbe), 32'(e_rbe));
        check({tag, ".RAMwe"}, 32'(RAMwe), 32'(e_rwe));
        check({tag, ".CPUread"}, 32'(CPUread), 32'(e_cread));
        if (be != 0 && mis == 0)
            check({tag, ".RAMwrite"}, 32'(RAMwrite), 32'(e_rwrite));
    endtask

    // Access held across one rising edge, then status flags checked.
    task automatic step(input string tag, input int addr, input int be, input int we,
                        input int wr, input int rd);
        int mis;
        apply(tag, addr, be, we, wr, rd, mis);
        @(posedge clk);
        if (mis != 0 && exp_err == 0 && reset === 1'b1) begin
            exp_err   = 1;
            exp_eaddr = addr;
        end
        #1;
        check({tag, ".misalign_err"}, 32'(misalign_err), 32'(exp_err));
        check({tag, ".err_addr"}, 32'(err_addr), 32'(exp_eaddr));
    endtask

    initial begin
        int mis;
        reset    = 1'b0;
        CPUaddr  = '0;
        CPUbe    = 2'b00;
        CPUwe    = 1'b0;
        CPUwrite = '0;
        RAMread  = '0;
        #2;
        check("reset.misalign_err", 32'(misalign_err), 32'd0);
        check("reset.err_addr", 32'(err_addr), 32'd0);

        // Combinational paths follow inputs while reset is held; no capture at this edge.
        step("in_reset_mis", 16'h0003, 3, 1, 16'h5555, 16'h1234);
        step("in_reset_byte", 16'h0005, 2, 0, 16'h0000, 16'h80AA);

        @(negedge clk);
        reset = 1'b1;

        step("ub_wr_even", 16'h0004, 1, 1, 16'h00BB, 16'h0000);
        step("ub_rd_even", 16'h0004, 1, 0, 16'h0000, 16'hAABB);
        step("ub_rd_odd", 16'h0005, 1, 0, 16'h0000, 16'hAABB);
        step("sb_rd_odd", 16'h0005, 2, 0, 16'h0000, 16'hAABB);
        step("sb_rd_even", 16'h0004, 2, 0, 16'h0000, 16'h7F80);
        step("word_wr", 16'h0010, 3, 1, 16'h1234, 16'h0000);
        step("word_rd", 16'h0010, 3, 0, 16'h0000, 16'hCAFE);
        step("ub_wr_odd", 16'h0101, 1, 1, 16'hC3A5, 16'h0000);
        step("mis_first", 16'h0007, 3, 1, 16'hDEAD, 16'hBEEF);
        check("mis_first.flag", 32'(misalign_err), 32'd1);
        check("mis_first.addr", 32'(err_addr), 32'h0007);
        step("mis_second", 16'h0009, 3, 1, 16'hDEAD, 16'hBEEF);
        check("mis_second.addr", 32'(err_addr), 32'h0007);
        step("idle_we", 16'h0022, 0, 1, 16'hFFFF, 16'hFFFF);

        // Mid-cycle asynchronous reset clears status without waiting for a clock edge.
        #3;
        reset = 1'b0;
        #1;
        exp_err   = 0;
        exp_eaddr = 0;
        check("async_rst.misalign_err", 32'(misalign_err), 32'(exp_err));
        check("async_rst.err_addr", 32'(err_addr), 32'(exp_eaddr));
        apply("rst_low_word", 16'h0040, 3, 0, 16'h0000, 16'h9876, mis);
        @(negedge clk);
        reset = 1'b1;

        step("post_rst_mis", 16'h00F1, 3, 0, 16'h0000, 16'h0000);
        for (int i = 0; i < 300; i++) begin
            step($sformatf("rand%0d", i), int'($urandom_range(0, 65535)),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 1)),
                 int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
